// File: rtl/touch_panel_pkg.sv
// Shared types and constants for the touch-panel SPI master.
package touch_panel_pkg;

  typedef enum logic [2:0] {StIdle, StSetup, StCmd, StData, StHold} state_e;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned STAT_DONE      = 0;
  localparam int unsigned STAT_DROPPED   = 1;
  localparam int unsigned STAT_NO_DEVICE = 2;
  localparam int unsigned STAT_IRQ_EN    = 8;

  localparam logic [7:0] DIV_MIN = 8'd2;

  localparam int unsigned CMD_BITS          = 8;
  localparam int unsigned DATA_BITS         = 16;
  localparam int unsigned RESULT_MSB_PERIOD = 1;
  localparam int unsigned RESULT_BITS       = 12;

  function automatic logic [7:0] clamp_div(logic [7:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/touch_panel_sync2.sv
// Two-flop synchronizer for asynchronous panel inputs.
module touch_panel_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/touch_panel_spi_master.sv
// Avalon-MM touch-panel (ADS7843-class) serial master: 24-DCLK conversion frames.
// Optional TOUCH_PANEL_BUSY_CHECK_EN: flag a missing panel from BUSY during the first data period.
module touch_panel_spi_master
  import touch_panel_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        touch_cs_n,
  output logic        touch_dclk,
  output logic        touch_din,
  input  logic        touch_dout,
  input  logic        touch_busy
);

  state_e      state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [7:0]  hp_div_q, hp_div_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [11:0] shift_q, shift_d;
  logic [11:0] data_q, data_d;
  logic [7:0]  div_q, div_d;
  logic        done_q, done_d;
  logic        dropped_q, dropped_d;
  logic        no_dev_q, no_dev_d;
  logic        skip_q, skip_d;
  logic        irq_en_q, irq_en_d;
  logic        cs_n_q, cs_n_d;
  logic        dclk_q, dclk_d;
  logic        din_q, din_d;
  logic [31:0] rd_d;

  logic        wr, boundary, dout_s;
  logic [22:0] wdata_unused;

  assign wr           = chipselect & ~write_n;
  assign boundary     = (hcnt_q == hp_div_q);
  assign wdata_unused = writedata[31:9];

  touch_panel_sync2 u_sync_dout (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (touch_dout),
    .q       (dout_s)
  );

`ifdef TOUCH_PANEL_BUSY_CHECK_EN
  logic busy_s;

  touch_panel_sync2 u_sync_busy (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (touch_busy),
    .q       (busy_s)
  );
`else
  logic busy_unused;
  assign busy_unused = touch_busy;
`endif

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    hp_div_d  = hp_div_q;
    bit_d     = bit_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    data_d    = data_q;
    div_d     = div_q;
    done_d    = done_q;
    dropped_d = dropped_q;
    no_dev_d  = no_dev_q;
    skip_d    = skip_q;
    irq_en_d  = irq_en_q;
    cs_n_d    = cs_n_q;
    dclk_d    = dclk_q;
    din_d     = din_q;

    if (wr && address == ADDR_DIV) div_d = clamp_div(writedata[7:0]);
    // Clears are applied first so a same-cycle frame completion wins.
    if (wr && address == ADDR_STATUS) begin
      if (writedata[STAT_DONE])      done_d    = 1'b0;
      if (writedata[STAT_DROPPED])   dropped_d = 1'b0;
      if (writedata[STAT_NO_DEVICE]) no_dev_d  = 1'b0;
      irq_en_d = writedata[STAT_IRQ_EN];
    end

    // A new DIV value is picked up only at half-period boundaries.
    if (state_q != StIdle) begin
      hcnt_d = boundary ? 8'd0 : hcnt_q + 8'd1;
      if (boundary) hp_div_d = div_q;
    end

    unique case (state_q)
      StIdle: begin
        if (wr && address == ADDR_CMD) begin
          state_d  = StSetup;
          cs_n_d   = 1'b0;
          cmd_d    = writedata[7:0];
          done_d   = 1'b0;
          hcnt_d   = 8'd0;
          hp_div_d = div_q;
          skip_d   = 1'b0;
        end
      end
      StSetup: begin
        if (boundary) begin
          state_d = StCmd;
          din_d   = cmd_q[7];
          bit_d   = '0;
        end
      end
      StCmd: begin
        if (boundary) begin
          if (!dclk_q) begin
            dclk_d = 1'b1;
          end else begin
            dclk_d = 1'b0;
            if (bit_q == 4'(CMD_BITS - 1)) begin
              state_d = StData;
              bit_d   = '0;
              din_d   = 1'b0;
            end else begin
              bit_d = bit_q + 4'd1;
              cmd_d = {cmd_q[6:0], 1'b0};
              din_d = cmd_q[6];
            end
          end
        end
      end
      StData: begin
        if (boundary) begin
          if (!dclk_q) begin
            dclk_d = 1'b1;
          end else begin
            if (bit_q >= 4'(RESULT_MSB_PERIOD) &&
                bit_q < 4'(RESULT_MSB_PERIOD + RESULT_BITS)) begin
              shift_d = {shift_q[10:0], dout_s};
            end
`ifdef TOUCH_PANEL_BUSY_CHECK_EN
            if (bit_q == '0 && !busy_s) begin
              skip_d   = 1'b1;
              no_dev_d = 1'b1;
            end
`endif
            dclk_d = 1'b0;
            if (bit_q == 4'(DATA_BITS - 1)) state_d = StHold;
            else                            bit_d   = bit_q + 4'd1;
          end
        end
      end
      StHold: begin
        if (boundary) begin
          state_d = StIdle;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          if (!skip_q) data_d = shift_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr && address == ADDR_CMD && state_q != StIdle) dropped_d = 1'b1;
  end

  always_comb begin
    rd_d = '0;
    unique case (address)
      ADDR_CMD:    rd_d[0]     = (state_q != StIdle);
      ADDR_DATA:   rd_d[11:0]  = data_q;
      ADDR_DIV:    rd_d[7:0]   = div_q;
      ADDR_STATUS: begin
        rd_d[STAT_DONE]      = done_q;
        rd_d[STAT_DROPPED]   = dropped_q;
        rd_d[STAT_NO_DEVICE] = no_dev_q;
        rd_d[STAT_IRQ_EN]    = irq_en_q;
      end
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      hp_div_q  <= 8'(DEFAULT_DIV);
      bit_q     <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      div_q     <= 8'(DEFAULT_DIV);
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      no_dev_q  <= 1'b0;
      skip_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      dclk_q    <= 1'b0;
      din_q     <= 1'b0;
      readdata  <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      hp_div_q  <= hp_div_d;
      bit_q     <= bit_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      div_q     <= div_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      no_dev_q  <= no_dev_d;
      skip_q    <= skip_d;
      irq_en_q  <= irq_en_d;
      cs_n_q    <= cs_n_d;
      dclk_q    <= dclk_d;
      din_q     <= din_d;
      readdata  <= rd_d;
    end
  end

  assign touch_cs_n = cs_n_q;
  assign touch_dclk = dclk_q;
  assign touch_din  = din_q;
  assign irq        = done_q & irq_en_q;

endmodule
